bip_uart_sequencer: RTL and testbench

- Command-driven controller between the UART FIFOs and the BIP2 core plus its instruction memory.
- Decodes host byte commands to load programs, run, single-step and report results.
- Holds the BIP in reset whenever it is not executing.
- Sequences replies back through the UART transmit FIFO.

---
 rtl/bip_uart_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_bip_uart_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bip_uart_sequencer.sv
// Host-command sequencer between the UART FIFOs and the BIP2 core: loads program memory,
// runs or single-steps the core, and reports status/ACC/PC back over the transmit FIFO.
module bip_uart_sequencer #(
  parameter int DBIT    = 8,
  parameter int AW      = 11,
  parameter int MAX_CYC = 1024
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_empty,
  input  logic [DBIT-1:0] rx_data,
  output logic            rd_uart,
  input  logic            tx_full,
  output logic [DBIT-1:0] tx_data,
  output logic            wr_uart,
  output logic            imem_we,
  output logic [AW-1:0]   imem_addr,
  output logic [15:0]     imem_wdata,
  output logic            bip_reset,
  input  logic [AW-1:0]   bip_pc,
  input  logic [15:0]     bip_instr,
  input  logic [15:0]     bip_acc,
  output logic            busy
);

  localparam int CW = $clog2(MAX_CYC + 1);

  localparam logic [DBIT-1:0] CH_L = DBIT'(8'h4C);
  localparam logic [DBIT-1:0] CH_R = DBIT'(8'h52);
  localparam logic [DBIT-1:0] CH_S = DBIT'(8'h53);
  localparam logic [DBIT-1:0] CH_C = DBIT'(8'h43);
  localparam logic [DBIT-1:0] CH_K = DBIT'(8'h4B);
  localparam logic [DBIT-1:0] CH_Q = DBIT'(8'h3F);
  localparam logic [DBIT-1:0] CH_H = DBIT'(8'h48);
  localparam logic [DBIT-1:0] CH_T = DBIT'(8'h54);

  typedef enum logic [3:0] {
    IDLE, GET_CNT, GET_HI, GET_LO, WRITE, RUN, STEP, STEP_CAP, REPLY, REPORT
  } state_t;

  state_t          state, state_nx;
  logic            rx_block;
  logic [DBIT-1:0] cnt_n, hi_q, lo_q, reply_q, status_q;
  logic [AW-1:0]   idx;
  logic [CW-1:0]   cyc;
  logic [15:0]     acc_q, pc_q;
  logic [2:0]      rep_idx;
  logic            rx_ok, halt, stop, last_word;
  logic [DBIT-1:0] rep_byte;

  // rx_block is set after every pop so the FIFO gets a cycle to advance its head
  assign rx_ok      = !rx_empty && !rx_block;
  assign halt       = (bip_instr == 16'h0000);
  assign stop       = halt || (cyc == CW'(MAX_CYC - 1));
  assign last_word  = (idx == AW'(cnt_n) - AW'(1));
  assign imem_addr  = idx;
  assign imem_wdata = {hi_q, lo_q};
  assign busy       = (state != IDLE);

  always_comb begin
    rep_byte = '0;
    case (rep_idx)
      3'd0:    rep_byte = status_q;
      3'd1:    rep_byte = acc_q[15:8];
      3'd2:    rep_byte = acc_q[7:0];
      3'd3:    rep_byte = pc_q[15:8];
      3'd4:    rep_byte = pc_q[7:0];
      default: rep_byte = '0;
    endcase
  end

  always_comb begin
    state_nx  = state;
    rd_uart   = 1'b0;
    wr_uart   = 1'b0;
    imem_we   = 1'b0;
    bip_reset = 1'b1;
    tx_data   = '0;
    case (state)
      IDLE: begin
        if (rx_ok) begin
          rd_uart = 1'b1;
          case (rx_data)
            CH_L:    state_nx = GET_CNT;
            CH_R:    state_nx = RUN;
            CH_S:    state_nx = STEP;
            default: state_nx = REPLY;
          endcase
        end
      end
      GET_CNT: begin
        if (rx_ok) begin
          rd_uart  = 1'b1;
          state_nx = (rx_data == '0) ? REPLY : GET_HI;
        end
      end
      GET_HI: begin
        if (rx_ok) begin
          rd_uart  = 1'b1;
          state_nx = GET_LO;
        end
      end
      GET_LO: begin
        if (rx_ok) begin
          rd_uart  = 1'b1;
          state_nx = WRITE;
        end
      end
      WRITE: begin
        imem_we  = 1'b1;
        state_nx = last_word ? REPLY : GET_HI;
      end
      RUN: begin
        bip_reset = 1'b0;
        if (stop) state_nx = REPORT;
      end
      STEP: begin
        bip_reset = 1'b0;
        state_nx  = STEP_CAP;
      end
      STEP_CAP: state_nx = REPORT;
      REPLY: begin
        tx_data = reply_q;
        if (!tx_full) begin
          wr_uart  = 1'b1;
          state_nx = IDLE;
        end
      end
      REPORT: begin
        tx_data = rep_byte;
        if (!tx_full) begin
          wr_uart = 1'b1;
          if (rep_idx == 3'd4) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rx_block <= 1'b1;
      cnt_n    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      reply_q  <= '0;
      status_q <= '0;
      idx      <= '0;
      cyc      <= '0;
      acc_q    <= '0;
      pc_q     <= '0;
      rep_idx  <= '0;
    end else begin
      state    <= state_nx;
      rx_block <= rd_uart;
      if (state != REPORT)  rep_idx <= '0;
      else if (wr_uart)     rep_idx <= rep_idx + 3'd1;
      case (state)
        IDLE: begin
          cyc <= '0;
          if (rd_uart) reply_q <= (rx_data == CH_C) ? CH_K : CH_Q;
        end
        GET_CNT: begin
          if (rd_uart) begin
            cnt_n   <= rx_data;
            idx     <= '0;
            reply_q <= CH_K;
          end
        end
        GET_HI: if (rd_uart) hi_q <= rx_data;
        GET_LO: if (rd_uart) lo_q <= rx_data;
        WRITE:  idx <= idx + AW'(1);
        // Snapshot is taken in the stop cycle, before the core is put back in reset
        RUN: begin
          cyc <= cyc + CW'(1);
          if (stop) begin
            acc_q    <= bip_acc;
            pc_q     <= 16'(bip_pc);
            status_q <= halt ? CH_H : CH_T;
          end
        end
        STEP_CAP: begin
          acc_q    <= bip_acc;
          pc_q     <= 16'(bip_pc);
          status_q <= CH_S;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bip_uart_sequencer.sv
// Directed bench for bip_uart_sequencer with a behavioural UART FIFO, instruction memory
// and a tiny BIP model (PC advances, ACC accumulates the fetched word, 0x0000 halts).
module tb_bip_uart_sequencer;
  localparam int AW = 11;

  logic            clk = 1'b0;
  logic            reset, rx_empty, rd_uart, tx_full, wr_uart, imem_we, bip_reset, busy;
  logic [7:0]      rx_data, tx_data;
  logic [AW-1:0]   imem_addr, bip_pc;
  logic [15:0]     imem_wdata, bip_instr, bip_acc;

  always #5 clk = ~clk;

  bip_uart_sequencer #(.DBIT(8), .AW(AW), .MAX_CYC(16)) dut (
    .clk(clk), .reset(reset), .rx_empty(rx_empty), .rx_data(rx_data), .rd_uart(rd_uart),
    .tx_full(tx_full), .tx_data(tx_data), .wr_uart(wr_uart), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .bip_reset(bip_reset),
    .bip_pc(bip_pc), .bip_instr(bip_instr), .bip_acc(bip_acc), .busy(busy)
  );

  logic [15:0] mem [0:2047];
  logic [7:0]  rxq [$];
  logic [7:0]  txlog [$];
  int checks = 0;
  int errors = 0;
  int we_cnt, low_cnt, full_wr, rd_cnt, wr_cnt;
  int rd_b2b = 0;
  logic prev_rd = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic refresh();
    rx_empty  = (rxq.size() == 0);
    rx_data   = rx_empty ? 8'h00 : rxq[0];
    bip_instr = mem[bip_pc];
  endtask

  task automatic clr();
    txlog.delete();
    we_cnt = 0; low_cnt = 0; full_wr = 0; rd_cnt = 0; wr_cnt = 0;
  endtask

  task automatic tick();
    logic s_rd, s_wr, s_we, s_bres;
    logic [7:0] s_tx, dummy;
    logic [AW-1:0] s_addr;
    logic [15:0] s_wd;
    @(negedge clk);
    s_rd = rd_uart; s_wr = wr_uart; s_we = imem_we; s_bres = bip_reset;
    s_tx = tx_data; s_addr = imem_addr; s_wd = imem_wdata;
    if (s_rd && prev_rd) rd_b2b++;
    prev_rd = s_rd;
    if (s_rd) rd_cnt++;
    if (s_wr) wr_cnt++;
    if (s_wr && tx_full) full_wr++;
    if (!s_bres) low_cnt++;
    if (s_we) we_cnt++;
    @(posedge clk);
    #1;
    if (s_rd && rxq.size() > 0) dummy = rxq.pop_front();
    if (s_wr) txlog.push_back(s_tx);
    if (s_we) mem[s_addr] = s_wd;
    if (s_bres) begin
      bip_pc = '0; bip_acc = '0;
    end else if (bip_instr != 16'h0000) begin
      bip_pc = bip_pc + 1'b1; bip_acc = bip_acc + bip_instr;
    end
    refresh();
  endtask

  task automatic send(input logic [7:0] b[$]);
    foreach (b[i]) rxq.push_back(b[i]);
    refresh();
  endtask

  task automatic run_tx(input string tag, input int n, input int budget);
    int k = 0;
    while (txlog.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk({tag, "_done"}, 32'(txlog.size() >= n), 32'd1);
    repeat (3) tick();
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_ntx"}, 32'(txlog.size()), 32'(n));
  endtask

  task automatic exp_tx(input string tag, input logic [7:0] e[$]);
    foreach (e[i]) begin
      if (i < txlog.size()) chk($sformatf("%s_b%0d", tag, i), 32'(txlog[i]), 32'(e[i]));
      else                  chk($sformatf("%s_b%0d", tag, i), 32'hDEAD, 32'(e[i]));
    end
  endtask

  initial begin
    logic [7:0] v [$];
    int lat;
    reset = 1'b1; tx_full = 1'b0; bip_pc = '0; bip_acc = '0;
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0001;
    clr();
    v = '{8'h7A}; send(v);
    #2 reset = 1'b0;
    repeat (4) tick();
    chk("rst_rd", 32'(rd_cnt), 32'd0);
    chk("rst_wr", 32'(wr_cnt), 32'd0);
    chk("rst_bip_low", 32'(low_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_txd", 32'(tx_data), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", 32'(imem_wdata), 32'd0);
    chk("rst_bip_reset", 32'(bip_reset), 32'd1);

    reset = 1'b1;
    lat = 0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (rd_cnt > 0 && lat == 0) lat = k;
    end
    chk("pop_latency", 32'(lat >= 1 && lat <= 2), 32'd1);
    run_tx("unknown", 1, 20);
    v = '{8'h3F}; exp_tx("unknown", v);

    clr(); v = '{8'h4C, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD}; send(v);
    run_tx("load2", 1, 100);
    chk("load2_we", 32'(we_cnt), 32'd2);
    chk("load2_m0", 32'(mem[0]), 32'h1234);
    chk("load2_m1", 32'(mem[1]), 32'hABCD);
    v = '{8'h4B}; exp_tx("load2", v);

    clr(); v = '{8'h4C, 8'h04, 8'h00, 8'h01, 8'h00, 8'h10, 8'h01, 8'h00, 8'h00, 8'h00}; send(v);
    run_tx("loadh", 1, 100);
    chk("loadh_m3", 32'(mem[3]), 32'h0000);
    clr(); v = '{8'h52}; send(v);
    run_tx("halt", 5, 100);
    v = '{8'h48, 8'h01, 8'h11, 8'h00, 8'h03}; exp_tx("halt", v);
    chk("halt_run_cycles", 32'(low_cnt), 32'd4);

    clr(); v = '{8'h4C, 8'h04, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h01}; send(v);
    run_tx("loadt", 1, 100);
    clr(); v = '{8'h52}; send(v);
    run_tx("tmo", 5, 100);
    v = '{8'h54, 8'h00, 8'h0F, 8'h00, 8'h0F}; exp_tx("tmo", v);
    chk("tmo_run_cycles", 32'(low_cnt), 32'd16);

    clr(); tx_full = 1'b1; v = '{8'h52, 8'h7A}; send(v);
    repeat (28) tick();
    chk("full_hold_ntx", 32'(txlog.size()), 32'd0);
    chk("full_busy", 32'(busy), 32'd1);
    chk("full_rx_kept", 32'(rxq.size()), 32'd1);
    tx_full = 1'b0;
    run_tx("full", 6, 100);
    v = '{8'h54, 8'h00, 8'h0F, 8'h00, 8'h0F, 8'h3F}; exp_tx("full", v);
    chk("full_wr_while_full", 32'(full_wr), 32'd0);

    clr(); v = '{8'h53}; send(v);
    run_tx("step", 5, 50);
    v = '{8'h53, 8'h00, 8'h01, 8'h00, 8'h01}; exp_tx("step", v);
    chk("step_low", 32'(low_cnt), 32'd1);

    clr(); v = '{8'h4C, 8'h00}; send(v);
    run_tx("l0", 1, 50);
    v = '{8'h4B}; exp_tx("l0", v);
    chk("l0_we", 32'(we_cnt), 32'd0);

    clr(); v = '{8'h43}; send(v);
    run_tx("clr", 1, 50);
    v = '{8'h4B}; exp_tx("clr", v);
    chk("clr_low", 32'(low_cnt), 32'd0);

    clr(); v = '{8'h4C, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55}; send(v);
    for (int k = 0; k < 100 && we_cnt < 2; k++) tick();
    repeat (4) tick();
    chk("part_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("part_rst_busy", 32'(busy), 32'd0);
    chk("part_rst_bip", 32'(bip_reset), 32'd1);
    chk("part_rst_we", 32'(imem_we), 32'd0);
    repeat (2) tick();
    reset = 1'b1;
    chk("part_m0", 32'(mem[0]), 32'h1122);
    chk("part_m1", 32'(mem[1]), 32'h3344);
    chk("part_m2", 32'(mem[2]), 32'h0001);
    clr(); v = '{8'h43}; send(v);
    run_tx("post_rst", 1, 50);
    v = '{8'h4B}; exp_tx("post_rst", v);
    chk("rd_back_to_back", 32'(rd_b2b), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
